// File: rtl/regfile_reader_pkg.sv
// Shared types for the register-file sweep reader.
package regfile_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/regfile_reader_if.sv
// Control, register-file read ports and valid/ready output stream of the sweep reader.
interface regfile_reader_if #(
    parameter int N = 5,
    parameter int W = 8
);

    logic         start;
    logic [N-1:0] base;
    logic [N:0]   count;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_addr;
    logic [W-1:0] out_data;
    logic         busy;
    logic         done;
    logic [W-1:0] checksum;

    modport master (
        input  start, base, count, rs1, rs2, out_ready,
        output addr_rs1, addr_rs2, out_valid, out_addr, out_data, busy, done, checksum
    );

    modport slave (
        output start, base, count, rs1, rs2, out_ready,
        input  addr_rs1, addr_rs2, out_valid, out_addr, out_data, busy, done, checksum
    );

endinterface

// File: rtl/regfile_pair_buf.sv
// Two-entry {addr, data} holding buffer, loaded in one cycle and drained head-first.
// Head is registered; pop shifts slot 1 into the head.
module regfile_pair_buf #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load1,
    input  logic         load2,
    input  logic [N-1:0] addr1,
    input  logic [W-1:0] data1,
    input  logic [N-1:0] addr2,
    input  logic [W-1:0] data2,
    input  logic         pop,
    output logic [N-1:0] head_addr,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         last
);

    logic [N-1:0] a0, a1;
    logic [W-1:0] d0, d1;
    logic         v0, v1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a0 <= '0;
            a1 <= '0;
            d0 <= '0;
            d1 <= '0;
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (load1) begin
            a0 <= addr1;
            d0 <= data1;
            v0 <= 1'b1;
            v1 <= load2;
            if (load2) begin
                a1 <= addr2;
                d1 <= data2;
            end
        end else if (pop) begin
            if (v1) begin
                a0 <= a1;
                d0 <= d1;
                v1 <= 1'b0;
            end else begin
                v0 <= 1'b0;
            end
        end
    end

    assign head_addr = a0;
    assign head_data = d0;
    assign empty     = ~v0;
    assign last      = v0 & ~v1;

endmodule

// File: rtl/regfile_reader.sv
// Sweeps a wrap-around register range two reads per fetch and streams (addr, data) words with a checksum.
// First word two cycles after start; output held stable while out_ready is low.
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    regfile_reader_if.master bus
);

    localparam int         REGS     = 2**N;
    localparam logic [N:0] REGS_CNT = (N+1)'(REGS);

    state_t       state;
    logic [N-1:0] cur;
    logic [N-1:0] addr1, addr2;
    logic [N:0]   remaining;
    logic [N:0]   cnt_sat;
    logic [W-1:0] csum;
    logic         valid, busy_q, done_q;
    logic         fetch_two, load1, load2, xfer;
    logic         buf_empty, buf_last;
    logic [N-1:0] head_addr;
    logic [W-1:0] head_data;

    assign cnt_sat   = (bus.count > REGS_CNT) ? REGS_CNT : bus.count;
    assign fetch_two = remaining >= (N+1)'(2);
    assign load1     = (state == FETCH);
    assign load2     = load1 & fetch_two;
    assign xfer      = valid & bus.out_ready & ~buf_empty;

    regfile_pair_buf #(.N(N), .W(W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load1     (load1),
        .load2     (load2),
        .addr1     (addr1),
        .data1     (bus.rs1),
        .addr2     (addr2),
        .data2     (bus.rs2),
        .pop       (xfer),
        .head_addr (head_addr),
        .head_data (head_data),
        .empty     (buf_empty),
        .last      (buf_last)
    );

    // Read addresses are registered one cycle ahead so they are valid throughout FETCH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cur       <= '0;
            remaining <= '0;
            csum      <= '0;
            valid     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr1     <= '0;
            addr2     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        csum <= '0;
                        if (cnt_sat != '0) begin
                            cur       <= bus.base;
                            remaining <= cnt_sat;
                            addr1     <= bus.base;
                            addr2     <= bus.base + N'(1);
                            busy_q    <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_two) begin
                        cur       <= cur + N'(2);
                        remaining <= remaining - (N+1)'(2);
                    end else begin
                        cur       <= cur + N'(1);
                        remaining <= remaining - (N+1)'(1);
                    end
                    valid <= 1'b1;
                    state <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        csum <= csum + head_data;
                        if (buf_last) begin
                            valid <= 1'b0;
                            if (remaining != '0) begin
                                addr1 <= cur;
                                addr2 <= cur + N'(1);
                                state <= FETCH;
                            end else begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= DONE;
                            end
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr_rs1  = addr1;
    assign bus.addr_rs2  = addr2;
    assign bus.out_valid = valid;
    assign bus.out_addr  = head_addr;
    assign bus.out_data  = head_data;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.checksum  = csum;

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: a behavioural register file feeds the read ports,
// expected words are queued at start and checked as the stream drains.
module tb_regfile_reader;

    localparam int N    = 5;
    localparam int W    = 8;
    localparam int REGS = 2**N;

    typedef struct packed {
        logic [N-1:0] a;
        logic [W-1:0] d;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_reader_if #(.N(N), .W(W)) bus ();

    regfile_reader #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] mem [REGS];
    assign bus.rs1 = mem[bus.addr_rs1];
    assign bus.rs2 = mem[bus.addr_rs2];

    word_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 0);
        check_eq({tag, "_busy"},  32'(bus.busy), 0);
        check_eq({tag, "_done"},  32'(bus.done), 0);
        check_eq({tag, "_csum"},  32'(bus.checksum), 0);
        check_eq({tag, "_rs1"},   32'(bus.addr_rs1), 0);
        check_eq({tag, "_rs2"},   32'(bus.addr_rs2), 0);
        check_eq({tag, "_oaddr"}, 32'(bus.out_addr), 0);
        check_eq({tag, "_odata"}, 32'(bus.out_data), 0);
    endtask

    // bp: out_ready follows 1,0,0 repeating; abort_after>0 resets after that many transfers;
    // bstart_cyc>0 pulses a spurious start in that cycle of the sweep.
    task automatic sweep(input int base, input int count, input bit bp,
                         input int abort_after, input int bstart_cyc);
        int           n, xfers, dones, done_cyc, cyc;
        logic [W-1:0] exp_sum;
        word_t        w;
        exp_q.delete();
        n       = (count > REGS) ? REGS : count;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            w.a = N'(base + i);
            w.d = mem[w.a];
            exp_sum = exp_sum + w.d;
            exp_q.push_back(w);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = N'(base);
        bus.count = (N+1)'(count);
        @(negedge clk);
        bus.start = 1'b0;
        bus.base  = N'($urandom);
        bus.count = (N+1)'($urandom);
        xfers    = 0;
        dones    = 0;
        done_cyc = 0;
        for (cyc = 1; cyc < 400; cyc++) begin
            bus.out_ready = bp ? (cyc % 3 == 1) : 1'b1;
            if (cyc == bstart_cyc) begin
                bus.start = 1'b1;
                bus.base  = N'($urandom);
                bus.count = (N+1)'(10);
            end else begin
                bus.start = 1'b0;
            end
            if (cyc == 1 && n > 0) check_eq("valid_t1", 32'(bus.out_valid), 0);
            if (cyc == 2 && n > 0) check_eq("valid_t2", 32'(bus.out_valid), 1);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", 32'(bus.out_valid), 0);
                end else begin
                    check_eq("out_addr", 32'(bus.out_addr), 32'(exp_q[0].a));
                    check_eq("out_data", 32'(bus.out_data), 32'(exp_q[0].d));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end
            if (bus.done) begin
                dones++;
                done_cyc = cyc;
                break;
            end
            if (n > 0) check_eq("busy", 32'(bus.busy), 1);
            if (abort_after > 0 && xfers == abort_after) break;
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (abort_after > 0) begin
            @(negedge clk);
            check_eq("no_done_pre_abort", 32'(bus.done), 0);
            rst = 1'b0;
            @(negedge clk);
            check_reset_outputs("abort");
            rst = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check_eq("abort_no_done", 32'(bus.done), 0);
                check_eq("abort_no_valid", 32'(bus.out_valid), 0);
            end
        end else begin
            check_eq("done_seen", dones, 1);
            check_eq("xfer_count", xfers, n);
            check_eq("checksum", 32'(bus.checksum), 32'(exp_sum));
            check_eq("busy_at_done", 32'(bus.busy), 0);
            check_eq("queue_drained", exp_q.size(), 0);
            if (!bp && n > 0) check_eq("done_latency", done_cyc, 3*(n/2) + 2*(n%2) + 1);
            if (n == 0) check_eq("done_latency0", done_cyc, 1);
            @(negedge clk);
            check_eq("done_pulse_width", 32'(bus.done), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < REGS; i++) mem[i] = W'($urandom);
        mem[0] = '0;

        rst = 1'b0;
        repeat (2) begin
            bus.start     = 1'($urandom);
            bus.base      = N'($urandom);
            bus.count     = (N+1)'($urandom);
            bus.out_ready = 1'($urandom);
            @(negedge clk);
        end
        check_reset_outputs("reset");
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;

        sweep(0, 32, 1'b0, 0, 0);
        sweep(30, 3, 1'b0, 0, 0);
        sweep(4, 6, 1'b1, 0, 0);
        sweep(9, 0, 1'b0, 0, 0);
        sweep(17, 40, 1'b0, 0, 0);
        sweep(7, 20, 1'b0, 3, 2);
        sweep(12, 5, 1'b1, 0, 0);
        sweep(25, 11, 1'b0, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_reader.md
Name: regfile_reader

Overview:
- Autonomous read-side master for the `Registro` register file. On `start` it sweeps a contiguous, wrap-around address range through both combinational read ports (`addr_rs1`/`rs1`, `addr_rs2`/`rs2`).
- It fetches two registers per fetch cycle and streams (address, data) words out over a valid/ready interface.
- It keeps a running modular checksum of every transferred word.
- Used for register-file dumps, debug readout and self-check after bulk writes.

Parameters:
- N, 5, address width; register file holds 2^N registers.
- W, 8, data width of each register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge).
- start  in  1  request a sweep; sampled only in IDLE.
- base  in  N  first address of the sweep; sampled with start.
- count  in  N+1  number of registers to read; sampled with start.
- addr_rs1  out  N  read address to register file port 1.
- addr_rs2  out  N  read address to register file port 2.
- rs1  in  W  combinational read data for addr_rs1.
- rs2  in  W  combinational read data for addr_rs2.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts word; transfer = out_valid & out_ready.
- out_addr  out  N  register address of the current output word.
- out_data  out  W  register contents of the current output word.
- busy  out  1  high from the cycle after accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse when the sweep completes.
- checksum  out  W  sum mod 2^W of all out_data transferred in the current or last sweep.

Behaviour:
- Reset values:
  - state=IDLE; out_valid=0, busy=0, done=0, checksum=0.
  - addr_rs1=0, addr_rs2=0, out_addr=0, out_data=0.
  - Buffer empty, remaining=0.
- Count handling: count > 2^N saturates to 2^N. The working counter `remaining` is N+1 bits.
- IDLE:
  - start=1 with count≥1: latch cur=base and remaining; clear checksum to 0; go to FETCH.
  - start=1 with count=0: clear checksum, pulse done the next cycle, stay IDLE, no transfers.
- FETCH (exactly 1 cycle):
  - Drive addr_rs1=cur and addr_rs2=(cur+1) mod 2^N.
  - Capture {cur, rs1} into buffer slot 0.
  - If remaining≥2, also capture {cur+1, rs2} into slot 1.
  - Advance cur by 1 or 2 (mod 2^N wrap) and decrement remaining by the same amount.
  - Go to SEND.
- SEND:
  - out_valid=1 and out_addr/out_data = head buffer slot.
  - These are held stable until a transfer occurs.
  - On each transfer: checksum += out_data (mod 2^W) and pop the head.
  - When the buffer empties on a transfer: go to FETCH if remaining>0, else go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Idle addresses: outside FETCH, addr_rs1/addr_rs2 hold their last values; no read side effects exist.
- Latency and throughput:
  - Accepted start at edge t gives FETCH during cycle t+1.
  - First out_valid=1 in cycle t+2.
  - With out_ready tied high, throughput is 2 words per 3 cycles.
- Register 0 is passed through as read (the register file returns 0); no special-casing.
- start while busy: ignored, no effect on the sweep.
- rst=0 mid-sweep:
  - All state returns to reset values on that edge; buffered words are discarded.
  - No done pulse is produced.
- Wrap: with base+k ≥ 2^N, addresses continue modulo 2^N (e.g. 31 → 0). count=2^N reads every register exactly once.

Decomposition:
- Package regfile_reader_pkg:
  - state enum {IDLE, FETCH, SEND, DONE}.
  - Helper constant REGS = 2**N, defined as a localparam in the module because it depends on N.
- Sub-module regfile_pair_buf:
  - 2-entry buffer of {addr, data}.
  - Ports: load1/load2, pop, head_addr/head_data, empty.
  - Instantiated once.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs → out_valid=0, busy=0, done=0, checksum=0, addr_rs1=addr_rs2=0.
- Full sweep: preload regfile with random data via write port (reg0=0); start, base=0, count=32, out_ready=1.
  - Expect 32 transfers with out_addr 0..31 in order, out_data = model value.
  - Expect done exactly once and checksum = model sum mod 256.
- Wrap and odd count: base=30, count=3.
  - Expect out_addr sequence 30, 31, 0.
  - The last FETCH captures only 1 word; done follows the third transfer.
- Backpressure: base=4, count=6, out_ready toggling 1,0,0,1,...
  - out_addr/out_data stay stable while out_valid=1 and out_ready=0.
  - No word is lost or duplicated; checksum matches.
- count=0 and count=40: count=0 → done pulse 1 cycle later, no out_valid, checksum=0. count=40 → exactly 32 transfers.
- Abort and busy-start:
  - Pulse start with count=10 during a sweep → ignored.
  - Drive rst=0 after 3 transfers → outputs return to reset values next cycle with no done.
  - A new start then runs correctly from its own base.
